// File: rtl/text_console.sv
// Writer end of the tram system port: turns a character stream into cursor-addressed word
// writes, with control codes, line wrap, ring-buffer scrolling and screen clear.
// Optional feature macro: TEXT_CONSOLE_TAB_EN (0x09 advances to the next 8-column stop).
module text_console #(
  parameter int ADDRW     = 11,
  parameter int WORD      = 32,
  parameter int TEXT_HRES = 84,
  parameter int TEXT_VRES = 24,
  parameter int DEPTH     = 2016
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic [3:0]       in_fg,
  input  logic [3:0]       in_bg,
  input  logic             clr,
  output logic [3:0]       tram_we,
  output logic [ADDRW-1:0] tram_addr,
  output logic [WORD-1:0]  tram_din,
  output logic [ADDRW-1:0] scroll_offs,
  output logic [6:0]       cur_col,
  output logic [4:0]       cur_row,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_ALL} state_t;

  localparam logic [ADDRW-1:0] HRES_A     = ADDRW'(TEXT_HRES);
  localparam logic [ADDRW-1:0] LAST_LINE  = ADDRW'(TEXT_HRES - 1);
  localparam logic [ADDRW-1:0] LAST_WORD  = ADDRW'(DEPTH - 1);
  localparam logic [6:0]       LAST_COL   = 7'(TEXT_HRES - 1);
  localparam logic [4:0]       LAST_ROW   = 5'(TEXT_VRES - 1);
  localparam logic [WORD-1:0]  SPACE_WORD = WORD'(32'h0000_0020);

  state_t           state, state_nxt;
  logic             run;
  logic [ADDRW-1:0] line_base, line_base_nxt;
  logic [ADDRW-1:0] scroll_offs_nxt;
  logic [ADDRW-1:0] cnt, cnt_nxt;
  logic [ADDRW-1:0] caddr, caddr_nxt;
  logic [6:0]       col_nxt;
  logic [4:0]       row_nxt;
  logic [3:0]       we_nxt;
  logic [ADDRW-1:0] addr_nxt;
  logic [WORD-1:0]  din_nxt;
  logic             accept;
  logic             advance;
`ifdef TEXT_CONSOLE_TAB_EN
  logic [7:0]       tab_col;
`endif

  // Every address in use is a multiple of the increment, so reaching DEPTH means wrap to 0.
  function automatic logic [ADDRW-1:0] add_wrap(input logic [ADDRW-1:0] a,
                                                input logic [ADDRW-1:0] inc);
    logic [ADDRW:0] s;
    s = {1'b0, a} + {1'b0, inc};
    if (s >= (ADDRW+1)'(DEPTH)) s = '0;
    return s[ADDRW-1:0];
  endfunction

  assign in_ready = run && (state == IDLE) && !clr;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state       <= IDLE;
      run         <= 1'b0;
      line_base   <= '0;
      scroll_offs <= '0;
      cnt         <= '0;
      caddr       <= '0;
      cur_col     <= '0;
      cur_row     <= '0;
      tram_we     <= '0;
      tram_addr   <= '0;
      tram_din    <= '0;
    end else begin
      state       <= state_nxt;
      run         <= 1'b1;
      line_base   <= line_base_nxt;
      scroll_offs <= scroll_offs_nxt;
      cnt         <= cnt_nxt;
      caddr       <= caddr_nxt;
      cur_col     <= col_nxt;
      cur_row     <= row_nxt;
      tram_we     <= we_nxt;
      tram_addr   <= addr_nxt;
      tram_din    <= din_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    line_base_nxt   = line_base;
    scroll_offs_nxt = scroll_offs;
    cnt_nxt         = cnt;
    caddr_nxt       = caddr;
    col_nxt         = cur_col;
    row_nxt         = cur_row;
    we_nxt          = '0;
    addr_nxt        = tram_addr;
    din_nxt         = tram_din;
    advance         = 1'b0;
`ifdef TEXT_CONSOLE_TAB_EN
    tab_col         = {1'b0, cur_col[6:3], 3'b000} + 8'd8;
`endif
    case (state)
      IDLE: begin
        if (run && clr) begin
          state_nxt = CLEAR_ALL;
          cnt_nxt   = '0;
        end else if (accept) begin
          case (in_char)
            8'h0A: begin
              col_nxt = '0;
              advance = 1'b1;
            end
            8'h0D: col_nxt = '0;
            8'h08: if (cur_col != '0) col_nxt = cur_col - 7'd1;
`ifdef TEXT_CONSOLE_TAB_EN
            8'h09: begin
              if (tab_col >= 8'(TEXT_HRES)) begin
                col_nxt = '0;
                advance = 1'b1;
              end else begin
                col_nxt = tab_col[6:0];
              end
            end
`endif
            default: begin
              we_nxt   = 4'hF;
              addr_nxt = line_base + ADDRW'(cur_col);
              din_nxt  = WORD'({in_fg, in_bg, 16'h0000, in_char});
              if (cur_col == LAST_COL) begin
                col_nxt = '0;
                advance = 1'b1;
              end else begin
                col_nxt = cur_col + 7'd1;
              end
            end
          endcase
          if (advance) begin
            if (cur_row < LAST_ROW) begin
              row_nxt       = cur_row + 5'd1;
              line_base_nxt = add_wrap(line_base, HRES_A);
            end else begin
              state_nxt = CLEAR_LINE;
              caddr_nxt = scroll_offs;
              cnt_nxt   = '0;
            end
          end
        end
      end
      CLEAR_LINE: begin
        we_nxt    = 4'hF;
        addr_nxt  = caddr;
        din_nxt   = SPACE_WORD;
        caddr_nxt = add_wrap(caddr, ADDRW'(1));
        cnt_nxt   = cnt + ADDRW'(1);
        // The cleared line becomes the new bottom line; the display moves down one line only now.
        if (cnt == LAST_LINE) begin
          state_nxt       = IDLE;
          line_base_nxt   = scroll_offs;
          scroll_offs_nxt = add_wrap(scroll_offs, HRES_A);
        end
      end
      CLEAR_ALL: begin
        we_nxt   = 4'hF;
        addr_nxt = cnt;
        din_nxt  = SPACE_WORD;
        cnt_nxt  = cnt + ADDRW'(1);
        if (cnt == LAST_WORD) begin
          state_nxt       = IDLE;
          line_base_nxt   = '0;
          scroll_offs_nxt = '0;
          col_nxt         = '0;
          row_nxt         = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console: characters, control codes, scrolling,
// screen clear, reset abort and line wrap.
module tb_text_console;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = '0;
  logic [3:0]  in_fg = '0;
  logic [3:0]  in_bg = '0;
  logic        clr = 1'b0;
  logic [3:0]  tram_we;
  logic [10:0] tram_addr;
  logic [31:0] tram_din;
  logic [10:0] scroll_offs;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  logic [10:0] so_model;

  text_console #(.ADDRW(11), .WORD(32), .TEXT_HRES(84), .TEXT_VRES(24), .DEPTH(2016)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_fg(in_fg), .in_bg(in_bg),
    .clr(clr), .tram_we(tram_we), .tram_addr(tram_addr), .tram_din(tram_din),
    .scroll_offs(scroll_offs), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Presents one character and returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg);
    int waited = 0;
    while (!in_ready && waited < 3000) begin
      tick();
      waited++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_char  = c;
    in_fg    = fg;
    in_bg    = bg;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called 1 ns after the edge that started a clear; checks n space writes from start on.
  task automatic run_clear(input string tag, input int n, input logic [10:0] start);
    int busy_cycles = 0;
    int writes = 0;
    int bad = 0;
    logic [10:0] exp_addr = start;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_we0"}, 32'(tram_we), 32'd0);
    busy_cycles = 1;
    for (int i = 0; i <= n; i++) begin
      tick();
      if (tram_we == 4'hF) begin
        if (tram_addr !== exp_addr || tram_din !== 32'h0000_0020) bad++;
        exp_addr = (exp_addr == 11'd2015) ? 11'd0 : exp_addr + 11'd1;
        writes++;
      end else if (tram_we !== 4'h0) begin
        bad++;
      end
      if (busy) busy_cycles++;
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(n));
    chk({tag, "_writes"}, 32'(writes), 32'(n));
    chk({tag, "_bad_writes"}, 32'(bad), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    #23;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(tram_we), 32'd0);
    chk("rst_scroll", 32'(scroll_offs), 32'd0);
    chk("rst_cursor", {cur_row, cur_col}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // First printable
    send(8'h41, 4'hF, 4'h1);
    chk("A_we", 32'(tram_we), 32'hF);
    chk("A_addr", 32'(tram_addr), 32'd0);
    chk("A_din", tram_din, 32'hF100_0041);
    chk("A_col", 32'(cur_col), 32'd1);
    tick();
    chk("idle_we", 32'(tram_we), 32'd0);

    // x, LF, y
    send(8'h78, 4'h7, 4'h0);
    chk("x_addr", 32'(tram_addr), 32'd1);
    chk("x_din", tram_din, 32'h7000_0078);
    send(8'h0A, 4'h0, 4'h0);
    chk("lf_we", 32'(tram_we), 32'd0);
    chk("lf_cursor", {cur_row, cur_col}, {5'd1, 7'd0});
    send(8'h79, 4'h2, 4'h3);
    chk("y_addr", 32'(tram_addr), 32'd84);
    chk("y_din", tram_din, 32'h2300_0079);
    chk("y_cursor", {cur_row, cur_col}, {5'd1, 7'd1});

    // CR, BS at column 0, BS mid-line
    send(8'h0D, 4'h0, 4'h0);
    chk("cr_col", 32'(cur_col), 32'd0);
    chk("cr_we", 32'(tram_we), 32'd0);
    send(8'h08, 4'h0, 4'h0);
    chk("bs0_cursor", {cur_row, cur_col}, {5'd1, 7'd0});
    send(8'h61, 4'h1, 4'h0);
    send(8'h62, 4'h1, 4'h0);
    chk("b_addr", 32'(tram_addr), 32'd85);
    send(8'h08, 4'h0, 4'h0);
    chk("bs_cursor", {cur_row, cur_col}, {5'd1, 7'd1});
    chk("bs_we", 32'(tram_we), 32'd0);

    // Walk down to the last row, then scroll once
    for (int i = 0; i < 22; i++) send(8'h0A, 4'h0, 4'h0);
    chk("row23", {cur_row, cur_col}, {5'd23, 7'd0});
    send(8'h7A, 4'h4, 4'h5);
    chk("z_addr", 32'(tram_addr), 32'd1932);
    send(8'h0A, 4'h0, 4'h0);
    chk("scroll_pending_offs", 32'(scroll_offs), 32'd0);
    run_clear("scroll1", 84, 11'd0);
    chk("scroll1_offs", 32'(scroll_offs), 32'd84);
    chk("scroll1_cursor", {cur_row, cur_col}, {5'd23, 7'd0});
    send(8'h71, 4'h6, 4'h2);
    chk("q_addr", 32'(tram_addr), 32'd0);
    chk("q_din", tram_din, 32'h6200_0071);

    // Scroll 23 more times: offsets walk the ring and wrap back to 0
    so_model = 11'd84;
    for (int s = 2; s <= 24; s++) begin
      send(8'h0A, 4'h0, 4'h0);
      run_clear("scrollN", 84, so_model);
      so_model = (so_model == 11'd1932) ? 11'd0 : so_model + 11'd84;
      chk("scrollN_offs", 32'(scroll_offs), 32'(so_model));
    end
    chk("scroll24_offs", 32'(scroll_offs), 32'd0);
    send(8'h72, 4'h3, 4'h3);
    chk("r_addr", 32'(tram_addr), 32'd1932);
    chk("r_cursor", {cur_row, cur_col}, {5'd23, 7'd1});

    // clr wins over a simultaneous character
    in_char  = 8'h5A;
    in_valid = 1'b1;
    clr      = 1'b1;
    #1;
    chk("clr_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    clr      = 1'b0;
    run_clear("clear_all", 2016, 11'd0);
    chk("clr_offs", 32'(scroll_offs), 32'd0);
    chk("clr_cursor", {cur_row, cur_col}, 32'd0);
    send(8'h6B, 4'h9, 4'hA);
    chk("k_addr", 32'(tram_addr), 32'd0);
    chk("k_din", tram_din, 32'h9A00_006B);

    // Reset in the middle of a full clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    chk("midclr_busy", 32'(busy), 32'd1);
    rst_sys_n = 1'b0;
    #1;
    chk("abort_we", 32'(tram_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_addr", 32'(tram_addr), 32'd0);
    chk("abort_cursor", {cur_row, cur_col}, 32'd0);
    @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    tick();
    send(8'h6D, 4'h1, 4'h2);
    chk("post_abort_addr", 32'(tram_addr), 32'd0);
    chk("post_abort_col", 32'(cur_col), 32'd1);

    // Line wrap at the last column
    for (int i = 1; i < 83; i++) send(8'h2E, 4'h1, 4'h0);
    chk("col83", 32'(cur_col), 32'd83);
    send(8'h45, 4'h8, 4'h0);
    chk("wrap_addr", 32'(tram_addr), 32'd83);
    chk("wrap_din", tram_din, 32'h8000_0045);
    chk("wrap_cursor", {cur_row, cur_col}, {5'd1, 7'd0});

    // TAB
    for (int i = 0; i < 3; i++) send(8'h2D, 4'h1, 4'h0);
    send(8'h09, 4'h5, 4'h6);
`ifdef TEXT_CONSOLE_TAB_EN
    chk("tab_we", 32'(tram_we), 32'd0);
    chk("tab_cursor", {cur_row, cur_col}, {5'd1, 7'd8});
    for (int i = 8; i < 81; i++) send(8'h2D, 4'h1, 4'h0);
    chk("col81", 32'(cur_col), 32'd81);
    send(8'h09, 4'h0, 4'h0);
    chk("tab_wrap_cursor", {cur_row, cur_col}, {5'd2, 7'd0});
    chk("tab_wrap_we", 32'(tram_we), 32'd0);
`else
    chk("tab_we", 32'(tram_we), 32'hF);
    chk("tab_addr", 32'(tram_addr), 32'd87);
    chk("tab_din", tram_din, 32'h5600_0009);
    chk("tab_cursor", {cur_row, cur_col}, {5'd1, 7'd4});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
